// File: rtl/foreign_insn_encoder.sv
// foreign_insn_encoder
//   Rebuilds x86 byte sequences from decoded instruction descriptors and packs
//   them into a little-endian stream of 8-byte words.
//
//   Pipeline:
//     1. The descriptor is assembled combinationally into up to 15 bytes.
//     2. The bytes are captured in a single stage register (S1).
//     3. S1 is appended to a 24-byte packing buffer.
//     4. Words are taken from buffer bytes 0..7.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    descriptor handshake
//   in_pfx..in_imm       descriptor fields (prefix, REX, map, opcode, modrm,
//                        sib, disp, imm size, imm)
//   in_last              flush the buffer once this instruction is packed
//   out_valid/out_ready  output word handshake
//   out_data             byte k in bits [8k+7:8k], byte 0 oldest
//   out_cnt              valid bytes in the word (1..8)
//   out_start            bit k set when byte k begins an instruction
module foreign_insn_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_pfx,
    input  logic [4:0]  in_rex,
    input  logic [1:0]  in_map,
    input  logic [7:0]  in_opcode,
    input  logic        in_has_modrm,
    input  logic [7:0]  in_modrm,
    input  logic [7:0]  in_sib,
    input  logic [31:0] in_disp,
    input  logic [1:0]  in_imm_sz,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_cnt,
    output logic [7:0]  out_start
);

    // ---------------- instruction assembly ----------------
    logic [1:0]   mod_f;
    logic [2:0]   rm_f;
    logic         need_sib;
    logic [2:0]   disp_n;
    logic [2:0]   imm_n;
    logic [7:0]   pfx_byte;
    logic [119:0] asm_bytes;
    logic [3:0]   asm_len;

    assign mod_f = in_modrm[7:6];
    assign rm_f  = in_modrm[2:0];

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        need_sib  = in_has_modrm && (mod_f != 2'b11) && (rm_f == 3'b100);
        disp_n    = 3'd0;
        imm_n     = 3'd0;
        pfx_byte  = 8'h00;
        asm_bytes = '0;
        asm_len   = 4'd0;

        if (in_has_modrm) begin
            if (mod_f == 2'b01)
                disp_n = 3'd1;
            else if (mod_f == 2'b10)
                disp_n = 3'd4;
            else if (mod_f == 2'b00 && rm_f == 3'b101)
                disp_n = 3'd4;
            else if (mod_f == 2'b00 && rm_f == 3'b100 && in_sib[2:0] == 3'b101)
                disp_n = 3'd4;
        end

        case (in_imm_sz)
            2'b01:   imm_n = 3'd1;
            2'b10:   imm_n = 3'd2;
            2'b11:   imm_n = 3'd4;
            default: imm_n = 3'd0;
        endcase

        case (in_pfx)
            2'b01:   pfx_byte = 8'h66;
            2'b10:   pfx_byte = 8'hF2;
            2'b11:   pfx_byte = 8'hF3;
            default: pfx_byte = 8'h00;
        endcase

        // Each field lands at the running length, so the byte order follows
        // the statement order below.
        if (in_pfx != 2'b00) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = pfx_byte;
            asm_len += 4'd1;
        end
        if (in_rex[4]) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = {4'h4, in_rex[3:0]};
            asm_len += 4'd1;
        end
        if (in_map != 2'b00) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = 8'h0F;
            asm_len += 4'd1;
        end
        if (in_map[1]) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = in_map[0] ? 8'h3A : 8'h38;
            asm_len += 4'd1;
        end
        asm_bytes[{asm_len, 3'b000} +: 8] = in_opcode;
        asm_len += 4'd1;
        if (in_has_modrm) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = in_modrm;
            asm_len += 4'd1;
        end
        if (need_sib) begin
            asm_bytes[{asm_len, 3'b000} +: 8] = in_sib;
            asm_len += 4'd1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < int'(disp_n)) begin
                asm_bytes[{asm_len, 3'b000} +: 8] = in_disp[8*i +: 8];
                asm_len += 4'd1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < int'(imm_n)) begin
                asm_bytes[{asm_len, 3'b000} +: 8] = in_imm[8*i +: 8];
                asm_len += 4'd1;
            end
        end
    end

    // ---------------- S1 stage and packing buffer ----------------
    logic         s1_valid;
    logic [119:0] s1_bytes;
    logic [3:0]   s1_len;
    logic         s1_last;

    // Invariant: buffer bytes at or above cnt_q are always zero, which lets
    // an append be a plain OR and makes bytes beyond out_cnt read as 0x00.
    logic [191:0] pk_data;
    logic [23:0]  pk_start;
    logic [4:0]   cnt_q;
    logic         flush_q;

    logic         pop;
    logic [4:0]   pop_n;
    logic [4:0]   base;
    logic         s1_move;
    logic [191:0] pk_data_nx;
    logic [23:0]  pk_start_nx;
    logic [4:0]   cnt_nx;

    always_comb begin
        out_valid = (cnt_q >= 5'd8) || (flush_q && cnt_q != 5'd0);
        out_cnt   = (cnt_q >= 5'd8) ? 4'd8 : cnt_q[3:0];
        pop       = out_valid && out_ready;
        pop_n     = pop ? {1'b0, out_cnt} : 5'd0;
        base      = cnt_q - pop_n;
        s1_move   = s1_valid && !flush_q &&
                    (({1'b0, base} + {2'b00, s1_len}) <= 6'd24);
        // S1 can take a new descriptor when empty or when it drains this edge.
        in_ready  = !rst && (!s1_valid || s1_move);

        pk_data_nx  = pk_data >> {pop_n, 3'b000};
        pk_start_nx = pk_start >> pop_n;
        cnt_nx      = base;
        if (s1_move) begin
            pk_data_nx  = pk_data_nx | ({72'd0, s1_bytes} << {base, 3'b000});
            pk_start_nx = pk_start_nx | (24'd1 << base);
            cnt_nx      = base + {1'b0, s1_len};
        end
    end

    assign out_data  = pk_data[63:0];
    assign out_start = pk_start[7:0];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer storage is reset too, because the append relies
            // on the bytes above the count being zero.
            s1_valid <= 1'b0;
            s1_bytes <= '0;
            s1_len   <= 4'd0;
            s1_last  <= 1'b0;
            pk_data  <= '0;
            pk_start <= '0;
            cnt_q    <= 5'd0;
            flush_q  <= 1'b0;
        end else begin
            pk_data  <= pk_data_nx;
            pk_start <= pk_start_nx;
            cnt_q    <= cnt_nx;

            if (s1_move && s1_last)
                flush_q <= 1'b1;
            else if (pop && cnt_nx == 5'd0)
                flush_q <= 1'b0;

            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_bytes <= asm_bytes;
                s1_len   <= asm_len;
                s1_last  <= in_last;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_foreign_insn_encoder.sv
// tb_foreign_insn_encoder
//   Directed bench for foreign_insn_encoder. A monitor captures every accepted
//   output word. Expected words are either hand-written constants or are
//   packed from an expected byte/start-flag stream built by the bench.
module tb_foreign_insn_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_pfx;
    logic [4:0]  in_rex;
    logic [1:0]  in_map;
    logic [7:0]  in_opcode;
    logic        in_has_modrm;
    logic [7:0]  in_modrm;
    logic [7:0]  in_sib;
    logic [31:0] in_disp;
    logic [1:0]  in_imm_sz;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_cnt;
    logic [7:0]  out_start;

    int n_tests = 0;
    int n_fail  = 0;

    logic [75:0] cap[$];   // {start, cnt, data} per accepted word
    logic [7:0]  exp_b[$];
    logic        exp_s[$];

    always #5 clk = ~clk;

    foreign_insn_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pfx       (in_pfx),
        .in_rex       (in_rex),
        .in_map       (in_map),
        .in_opcode    (in_opcode),
        .in_has_modrm (in_has_modrm),
        .in_modrm     (in_modrm),
        .in_sib       (in_sib),
        .in_disp      (in_disp),
        .in_imm_sz    (in_imm_sz),
        .in_imm       (in_imm),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_cnt      (out_cnt),
        .out_start    (out_start)
    );

    // Inputs change just after posedge, so negedge sees the settled handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            cap.push_back({out_start, out_cnt, out_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] pfx, input logic [4:0] rex, input logic [1:0] map,
                        input logic [7:0] op, input logic has_modrm, input logic [7:0] modrm,
                        input logic [7:0] sib, input logic [31:0] disp, input logic [1:0] imm_sz,
                        input logic [31:0] imm, input logic last);
        bit ok = 0;
        in_pfx = pfx; in_rex = rex; in_map = map; in_opcode = op;
        in_has_modrm = has_modrm; in_modrm = modrm; in_sib = sib; in_disp = disp;
        in_imm_sz = imm_sz; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("send_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d, input logic [3:0] c,
                               input logic [7:0] s);
        logic [75:0] w;
        int k = 0;
        while (cap.size() == 0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (cap.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            w = cap.pop_front();
            check({tag, "_data"}, w[63:0], d);
            check({tag, "_cnt"}, 64'(w[67:64]), 64'(c));
            check({tag, "_start"}, 64'(w[75:68]), 64'(s));
        end
    endtask

    task automatic push_b(input logic [7:0] b, input logic first);
        exp_b.push_back(b);
        exp_s.push_back(first);
    endtask

    // Packs the expected byte stream into 8-byte words (the tail is partial).
    task automatic expect_stream(input string tag);
        logic [63:0] d;
        logic [7:0]  s;
        int          n;
        int          w = 0;
        while (exp_b.size() > 0) begin
            d = 64'd0;
            s = 8'd0;
            n = (exp_b.size() >= 8) ? 8 : exp_b.size();
            for (int i = 0; i < n; i++) begin
                d[8*i +: 8] = exp_b.pop_front();
                s[i]        = exp_s.pop_front();
            end
            expect_word($sformatf("%s_w%0d", tag, w), d, 4'(n), s);
            w++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_pfx = 0; in_rex = 0; in_map = 0; in_opcode = 0; in_has_modrm = 0;
        in_modrm = 0; in_sib = 0; in_disp = 0; in_imm_sz = 0; in_imm = 0; in_last = 0;

        // ---- reset state ----
        cycles(3);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_out_start", 64'(out_start), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // ---- reg-reg with 0x66 prefix, 0F map; also two-cycle latency ----
        send(2'b01, 5'h00, 2'b01, 8'hAF, 1'b1, 8'hC1, 8'h00, 32'h0, 2'b00, 32'h0, 1'b1);
        @(negedge clk);
        check("lat_s1_not_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'd1);
        expect_word("imul", 64'h00000000_C1AF0F66, 4'd4, 8'h01);

        // ---- SIB + disp8, then RIP-style disp32 ----
        send(2'b00, 5'h00, 2'b00, 8'h8B, 1'b1, 8'h44, 8'h24, 32'h08, 2'b00, 32'h0, 1'b1);
        send(2'b00, 5'h00, 2'b00, 8'h8B, 1'b1, 8'h05, 8'h00, 32'h12345678, 2'b00, 32'h0, 1'b1);
        expect_word("sib_d8", 64'h00000000_0824448B, 4'd4, 8'h01);
        expect_word("disp32", 64'h00001234_5678058B, 4'd6, 8'h01);

        // ---- 15-byte maximum ----
        send(2'b11, 5'b11000, 2'b11, 8'h0F, 1'b1, 8'h84, 8'h25, 32'hDDCCBBAA, 2'b11,
             32'h44332211, 1'b1);
        expect_word("max_w0", 64'hAA25840F_3A0F48F3, 4'd8, 8'h01);
        expect_word("max_w1", 64'h00443322_11DDCCBB, 4'd7, 8'h00);

        // ---- streaming twelve 2-byte instructions ----
        for (int i = 0; i < 12; i++) begin
            push_b(8'h90, 1'b1);
            push_b(8'hC0, 1'b0);
            send(2'b00, 5'h00, 2'b00, 8'h90, 1'b1, 8'hC0, 8'h00, 32'h0, 2'b00, 32'h0,
                 (i == 11) ? 1'b1 : 1'b0);
        end
        expect_stream("stream");
        cycles(3);
        @(negedge clk);
        check("stream_drained_valid", 64'(out_valid), 64'd0);
        check("stream_drained_cnt", 64'(out_cnt), 64'd0);
        @(posedge clk);
        #1;

        // ---- backpressure: five 6-byte instructions against a 24-byte buffer ----
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] dsp;
            dsp = 32'h03020100 + 32'(i) * 32'h10101010;
            push_b(8'hB0 + 8'(i), 1'b1);
            push_b(8'h05, 1'b0);
            for (int b = 0; b < 4; b++) push_b(dsp[8*b +: 8], 1'b0);
            send(2'b00, 5'h00, 2'b00, 8'hB0 + 8'(i), 1'b1, 8'h05, 8'h00, dsp, 2'b00, 32'h0,
                 (i == 4) ? 1'b1 : 1'b0);
        end
        cycles(3);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_cnt", 64'(out_cnt), 64'd8);
        check("bp_no_words_yet", 64'(cap.size()), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_stream("bp");

        // ---- reset mid-stream with 13 bytes buffered ----
        out_ready = 1'b0;
        send(2'b00, 5'h00, 2'b00, 8'h8B, 1'b1, 8'h05, 8'h00, 32'hA1A2A3A4, 2'b00, 32'h0, 1'b0);
        send(2'b00, 5'h00, 2'b00, 8'h8B, 1'b1, 8'h05, 8'h00, 32'hB1B2B3B4, 2'b00, 32'h0, 1'b0);
        send(2'b00, 5'h00, 2'b00, 8'hC3, 1'b0, 8'h00, 8'h00, 32'h0, 2'b00, 32'h0, 1'b0);
        cycles(3);
        @(negedge clk);
        check("prerst_valid", 64'(out_valid), 64'd1);
        check("prerst_cnt", 64'(out_cnt), 64'd8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_cnt", 64'(out_cnt), 64'd0);
        check("midrst_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, 5'h00, 2'b00, 8'hC3, 1'b0, 8'h00, 8'h00, 32'h0, 2'b00, 32'h0, 1'b1);
        expect_word("fresh", 64'h00000000_000000C3, 4'd1, 8'h01);

        cycles(5);
        check("no_extra_words", 64'(cap.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/foreign_insn_encoder.md
# foreign_insn_encoder

Encoder for the foreign (x86) instruction front end: it takes one decoded instruction descriptor per handshake and rebuilds the x86 byte sequence (legacy prefix, REX, escape map, opcode, modrm, sib, displacement, immediate). A byte-packing buffer turns the variable-length instructions into a little-endian stream of 8-byte words. It feeds the foreign decoder's fetch-window input, and also serves as a self-check and replay source for decoded instruction streams.

## Interface
- No parameters. Buffer capacity is fixed at 24 bytes; output word is 8 bytes.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted on an edge where in_valid & in_ready
- in_pfx  in  2  legacy prefix: 00 none, 01 0x66, 10 0xF2, 11 0xF3
- in_rex  in  5  [4] REX present, [3:0] WRXB; emitted byte is 0x40|WRXB
- in_map  in  2  00 one-byte, 01 0x0F, 10 0x0F 0x38, 11 0x0F 0x3A
- in_opcode  in  8  opcode byte
- in_has_modrm  in  1  modrm present
- in_modrm  in  8  modrm byte
- in_sib  in  8  sib byte, used only when required by modrm
- in_disp  in  32  displacement; low bytes used
- in_imm_sz  in  2  00 none, 01 imm8, 10 imm16, 11 imm32
- in_imm  in  32  immediate; low bytes used
- in_last  in  1  flush the buffer after this instruction
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts the word on out_valid & out_ready
- out_data  out  64  byte k in bits [8k+7:8k]; byte 0 is the oldest
- out_cnt  out  4  valid bytes in the word, 1..8
- out_start  out  8  bit k set when byte k is the first byte of an instruction

## Operation
- Byte order: pfx, REX, map bytes (0x0F, then 0x38/0x3A), opcode, modrm, sib, disp (LE), imm (LE).
- sib is present when has_modrm, mod!=11 and rm==100.
- Displacement size, evaluated only when has_modrm:
  - mod==01: 1 byte.
  - mod==10: 4 bytes.
  - mod==00 & rm==101: 4 bytes.
  - mod==00 & rm==100 & sib[2:0]==101: 4 bytes.
  - Otherwise: none.
- Immediate size: 0, 1, 2 or 4 bytes from in_imm_sz.
- Length = sum of the above; range 1..15. No length check beyond 15 is needed, since the field maximum is 15.
- Stage S1 register: the assembled 15-byte vector, its length L, and the last flag. A descriptor is accepted when S1 is empty or S1 moves out on the same edge.
- Packer buffer: 24 bytes, count C in 0..24.
- S1 moves into the buffer when both hold:
  - no flush is pending;
  - (C - P) + L <= 24, where P is the pop size this edge (min(C,8) if popping, else 0).
- The moved bytes are appended at position C-P. out_start bookkeeping marks the first byte of each instruction; marks shift with the data.
- out_valid = (C >= 8) | (flush_pend & C > 0). Output comes from buffer bytes 0..7; out_cnt = min(C,8). Bytes beyond out_cnt read as 0x00 and their start bits as 0.
- Pop: the buffer shifts down by out_cnt and C decreases by out_cnt.
- Push and pop on the same edge: new C = C - P + L.
- flush_pend is set when an S1 entry with last=1 enters the buffer. It clears on the edge where the final pop makes C=0. No S1 move is allowed while flush_pend=1.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 on the first cycle after rst falls. out_valid=0, out_data=0, out_cnt=0, out_start=0, C=0, S1 empty, flush_pend=0.
- Latency: a descriptor accepted at edge E0 is in S1 after E0 and enters the buffer at E1 if space allows. Earliest out_valid is in the cycle after E1, so minimum latency is 2 cycles.
- Throughput: one descriptor per cycle while space allows, one word per cycle at the output.
- out_data, out_cnt and out_start are held stable while out_valid & ~out_ready.
- in_ready depends on out_ready combinationally through P. Inputs are sampled only on a handshake edge.
- rst mid-operation discards S1 and the buffer contents; no partial word is emitted.

## Test plan
- Reg-reg with prefix: pfx=01, map=01, op=AF, modrm=C1, last=1 -> one word, low 32 bits 0xC1AF0F66, out_cnt=4, out_start=0x01.
- SIB + disp8: op=8B, modrm=44, sib=24, disp=08, last=1 -> bytes 8B 44 24 08, out_cnt=4. Then modrm=05, disp=0x12345678 -> bytes 8B 05 78 56 34 12, out_cnt=6.
- 15-byte maximum:
  - Stimulus: pfx=11, rex=1_1000, map=11, op=0F, modrm=84, sib=25, disp=0xDDCCBBAA, imm_sz=11, imm=0x44332211, last=1.
  - Response: words F3 48 0F 3A 0F 84 25 AA (cnt 8, start 0x01), then BB CC DD 11 22 33 44 (cnt 7, start 0x00).
- Streaming: twelve 2-byte instructions (op=90, modrm=C0), with last=1 only on the 12th -> three full words, each start=0x55, C ends at 0.
- Backpressure: out_ready=0 while descriptors of length 6 are pushed -> the buffer fills to 24 with 4 instructions (1 more in S1) and in_ready stays low. Releasing out_ready recovers every byte in order with no loss or duplication.
- Reset mid-stream: rst asserted with C=13 -> out_valid=0 the next cycle, and the next instruction starts a fresh word at byte 0.
